// File: rtl/vtage_pkg.sv
// Shared types and default constants for the VTAGE update path.
`ifndef P_TAG_WIDTH
`define P_TAG_WIDTH 8
`endif

package vtage_pkg;

    localparam int unsigned VTAGE_NUM_COMP    = 4;
    localparam int unsigned VTAGE_INDEX_WIDTH = 8;
    localparam int unsigned VTAGE_TAG_WIDTH   = `P_TAG_WIDTH;
    localparam int unsigned VTAGE_DECAY_WIDTH = 4;

    // Update controller sequencing: accept, provider training, allocation.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_ALLOC = 2'd2
    } vtage_state_e;

    // Feedback record as captured at accept, for the default geometry.
    typedef struct packed {
        logic [VTAGE_INDEX_WIDTH-1:0]                fb_value;
        logic [VTAGE_NUM_COMP*VTAGE_TAG_WIDTH-1:0]   fb_tag;
        logic [VTAGE_NUM_COMP*VTAGE_INDEX_WIDTH-1:0] ent_value;
        logic [VTAGE_NUM_COMP-1:0]                   tag_match;
        logic [VTAGE_NUM_COMP-1:0]                   alloc_avail;
        logic [VTAGE_NUM_COMP-1:0]                   conf_sat;
    } vtage_rec_t;

endpackage

// File: rtl/vtage_prio_sel.sv
// Provider (highest matching) and allocation (lowest free above provider) selection.
module vtage_prio_sel #(
    parameter int unsigned P_N     = 4,
    parameter int unsigned LP_IDX_W = (P_N > 1) ? $clog2(P_N) : 1
) (
    input  logic [P_N-1:0]      hi_vec_i,
    input  logic [P_N-1:0]      lo_vec_i,
    output logic                hi_vld_o,
    output logic [LP_IDX_W-1:0] hi_idx_o,
    output logic [P_N-1:0]      above_o,
    output logic                lo_vld_o,
    output logic [LP_IDX_W-1:0] lo_idx_o
);

    // Highest set bit first, then candidates strictly above it, then lowest candidate.
    always_comb begin
        hi_vld_o = 1'b0;
        hi_idx_o = '0;
        above_o  = '0;
        lo_vld_o = 1'b0;
        lo_idx_o = '0;
        for (int i = 0; i < int'(P_N); i++) begin
            if (hi_vec_i[i]) begin
                hi_vld_o = 1'b1;
                hi_idx_o = LP_IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(P_N); i++) begin
            above_o[i] = !hi_vld_o || (i > int'(hi_idx_o));
        end
        for (int i = int'(P_N) - 1; i >= 0; i--) begin
            if (lo_vec_i[i] && above_o[i]) begin
                lo_vld_o = 1'b1;
                lo_idx_o = LP_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vtage_update_ctrl.sv
// Commit-side VTAGE training and allocation controller.
module vtage_update_ctrl
    import vtage_pkg::*;
#(
    parameter int unsigned P_NUM_COMP     = VTAGE_NUM_COMP,
    parameter int unsigned LP_INDEX_WIDTH = VTAGE_INDEX_WIDTH,
    parameter int unsigned P_TAG_WIDTH    = `P_TAG_WIDTH,
    parameter int unsigned P_DECAY_WIDTH  = VTAGE_DECAY_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 fb_valid_i,
    output logic                                 fb_ready_o,
    input  logic [LP_INDEX_WIDTH-1:0]            fb_value_i,
    input  logic [P_NUM_COMP*P_TAG_WIDTH-1:0]    fb_tag_i,
    input  logic [P_NUM_COMP*LP_INDEX_WIDTH-1:0] ent_value_i,
    input  logic [P_NUM_COMP-1:0]                ent_tag_match_i,
    input  logic [P_NUM_COMP-1:0]                ent_alloc_avail_i,
    input  logic [P_NUM_COMP-1:0]                ent_conf_sat_i,
    output logic [P_NUM_COMP-1:0]                ud_incr_conf_o,
    output logic [P_NUM_COMP-1:0]                ud_rst_conf_o,
    output logic [P_NUM_COMP-1:0]                ud_incr_use_o,
    output logic [P_NUM_COMP-1:0]                ud_decr_use_o,
    output logic [P_NUM_COMP-1:0]                ud_rst_use_o,
    output logic [P_NUM_COMP-1:0]                ud_load_tag_o,
    output logic [P_NUM_COMP-1:0]                ud_load_value_o,
    output logic [P_TAG_WIDTH-1:0]               ud_tag_o,
    output logic [LP_INDEX_WIDTH-1:0]            ud_value_o,
    output logic                                 alloc_fail_o
);

    localparam int unsigned LP_IDX_W = (P_NUM_COMP > 1) ? $clog2(P_NUM_COMP) : 1;

    // Record as held between accept and the end of allocation.
    typedef struct packed {
        logic [LP_INDEX_WIDTH-1:0]            fb_value;
        logic [P_NUM_COMP*P_TAG_WIDTH-1:0]    fb_tag;
        logic [P_NUM_COMP*LP_INDEX_WIDTH-1:0] ent_value;
        logic [P_NUM_COMP-1:0]                tag_match;
        logic [P_NUM_COMP-1:0]                alloc_avail;
        logic [P_NUM_COMP-1:0]                conf_sat;
    } rec_t;

    vtage_state_e             state_q, state_d;
    rec_t                     rec_q;
    logic [P_DECAY_WIDTH-1:0] decay_q, decay_d;

    logic                  prov_vld, alloc_vld, prov_hit, prov_sat;
    logic [LP_IDX_W-1:0]   prov_idx, alloc_idx;
    logic [P_NUM_COMP-1:0] cand, prov_oh, alloc_oh;

    assign fb_ready_o = (state_q == ST_IDLE);

    vtage_prio_sel #(
        .P_N      (P_NUM_COMP),
        .LP_IDX_W (LP_IDX_W)
    ) u_prio_sel (
        .hi_vec_i (rec_q.tag_match),
        .lo_vec_i (rec_q.alloc_avail),
        .hi_vld_o (prov_vld),
        .hi_idx_o (prov_idx),
        .above_o  (cand),
        .lo_vld_o (alloc_vld),
        .lo_idx_o (alloc_idx)
    );

    // Provider value check and one-hot selects, all from captured state.
    always_comb begin
        prov_hit = (rec_q.ent_value[int'(prov_idx)*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] == rec_q.fb_value);
        prov_sat = rec_q.conf_sat[prov_idx];
        prov_oh  = '0;
        prov_oh[prov_idx] = prov_vld;
        alloc_oh = '0;
        alloc_oh[alloc_idx] = alloc_vld;
    end

    // State, capture and decay registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rec_q   <= '0;
            decay_q <= '0;
        end else begin
            state_q <= state_d;
            decay_q <= decay_d;
            if ((state_q == ST_IDLE) && fb_valid_i) begin
                rec_q.fb_value    <= fb_value_i;
                rec_q.fb_tag      <= fb_tag_i;
                rec_q.ent_value   <= ent_value_i;
                rec_q.tag_match   <= ent_tag_match_i;
                rec_q.alloc_avail <= ent_alloc_avail_i;
                rec_q.conf_sat    <= ent_conf_sat_i;
            end
        end
    end

    // Next state and update strobe decode.
    always_comb begin
        state_d         = state_q;
        decay_d         = decay_q;
        ud_incr_conf_o  = '0;
        ud_rst_conf_o   = '0;
        ud_incr_use_o   = '0;
        ud_decr_use_o   = '0;
        ud_rst_use_o    = '0;
        ud_load_tag_o   = '0;
        ud_load_value_o = '0;
        ud_tag_o        = '0;
        ud_value_o      = '0;
        alloc_fail_o    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fb_valid_i) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = ST_ALLOC;
                if (prov_vld) begin
                    if (prov_hit) begin
                        ud_incr_conf_o = prov_oh;
                        if (prov_sat) ud_incr_use_o = prov_oh;
                        state_d = ST_IDLE;
                    end else begin
                        ud_rst_conf_o   = prov_oh;
                        ud_load_value_o = prov_oh;
                        ud_value_o      = rec_q.fb_value;
                        if (prov_sat) ud_decr_use_o = prov_oh;
                    end
                end
            end
            ST_ALLOC: begin
                state_d = ST_IDLE;
                if (alloc_vld) begin
                    ud_load_tag_o   = alloc_oh;
                    ud_load_value_o = alloc_oh;
                    ud_rst_conf_o   = alloc_oh;
                    ud_rst_use_o    = alloc_oh;
                    ud_tag_o        = rec_q.fb_tag[int'(alloc_idx)*P_TAG_WIDTH +: P_TAG_WIDTH];
                    ud_value_o      = rec_q.fb_value;
                end else if (|cand) begin
                    // Entries floor useful at 0, so the global decay can OR over candidates.
                    ud_decr_use_o = (decay_q == '1) ? '1 : cand;
                    alloc_fail_o  = 1'b1;
                    decay_d       = decay_q + P_DECAY_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
